// File: rtl/antares_pipe_pkg.sv
// Shared definitions for the Antares pipeline control block:
// sequencer state encoding and default watchdog sizing.
package antares_pipe_pkg;

    localparam logic [1:0] CTL_RUN   = 2'd0;
    localparam logic [1:0] CTL_PEND  = 2'd1;
    localparam logic [1:0] CTL_FLUSH = 2'd2;
    localparam logic [1:0] CTL_IWAIT = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = CTL_RUN,
        ST_PEND  = CTL_PEND,
        ST_FLUSH = CTL_FLUSH,
        ST_IWAIT = CTL_IWAIT
    } ctl_state_e;

    localparam int DEF_STALL_TIMEOUT = 1024;
    localparam int DEF_TO_WIDTH      = 16;

endpackage

// File: rtl/antares_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles (saturating) and raises
// a sticky flag once the stall has lasted STALL_TIMEOUT cycles.
module antares_stall_watchdog
    import antares_pipe_pkg::*;
#(
    parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
    parameter int TO_WIDTH      = DEF_TO_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic stall,
    output logic stall_timeout
);

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(STALL_TIMEOUT - 1);
    localparam logic [TO_WIDTH-1:0] CNT_MAX = '1;

    logic [TO_WIDTH-1:0] cnt_q;
    logic                flag_q;

    // Consecutive-stall counter; clears on any free cycle, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (!stall)
            cnt_q <= '0;
        else if (cnt_q != CNT_MAX)
            cnt_q <= cnt_q + 1'b1;
    end

    // Sticky flag: set when the stall is still present at count STALL_TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (rst)
            flag_q <= 1'b0;
        else if (stall && (cnt_q >= TO_LAST))
            flag_q <= 1'b1;
    end

    assign stall_timeout = flag_q;

endmodule

// File: rtl/antares_pipeline_control.sv
// Antares five-stage pipeline stall/flush sequencer.
// Stall requests are merged back-to-front into per-register holds; an
// exception taken at MEM is sequenced RUN -> (PEND) -> FLUSH -> (IWAIT) -> RUN.
// Optional build macro ANTARES_PIPE_PERF_EN adds stall-cycle and flush counters.
module antares_pipeline_control
    import antares_pipe_pkg::*;
#(
    parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
    parameter int TO_WIDTH      = DEF_TO_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic if_stall_req,
    input  logic id_stall_req,
    input  logic ex_stall_req,
    input  logic mem_stall_req,
    input  logic exc_req,
    output logic if_stall,
    output logic id_stall,
    output logic ex_stall,
    output logic mem_stall,
    output logic wb_stall,
    output logic if_flush,
    output logic id_flush,
    output logic ex_flush,
    output logic mem_flush,
    output logic pc_redirect,
    output logic ctl_busy,
    output logic stall_timeout
`ifdef ANTARES_PIPE_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    ctl_state_e state_q, state_nx, cur_st;
    logic       wdog_flag;

    // Output decode treats an asserted reset as RUN so nothing sequencer-driven leaks out.
    assign cur_st = rst ? ST_RUN : state_q;

    // Stall chain: each register holds if anything downstream holds.
    always_comb begin
        mem_stall = mem_stall_req;
        wb_stall  = mem_stall_req;
        ex_stall  = mem_stall_req | ex_stall_req;
        id_stall  = ex_stall | id_stall_req;
        if_stall  = id_stall | if_stall_req;
        case (cur_st)
            ST_FLUSH: begin
                // let bubbles enter the front end; the MEM/WB holds stay intact
                ex_stall = 1'b0;
                id_stall = 1'b0;
                if_stall = 1'b0;
            end
            ST_IWAIT: if_stall = 1'b1;
            default: ;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_nx;
    end

    // Next-state and flush/redirect decode.
    always_comb begin
        state_nx    = state_q;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        mem_flush   = 1'b0;
        pc_redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc_req)
                    state_nx = mem_stall_req ? ST_PEND : ST_FLUSH;
            end
            ST_PEND: begin
                if (!mem_stall_req)
                    state_nx = ST_FLUSH;
            end
            ST_FLUSH: begin
                if_flush    = 1'b1;
                id_flush    = 1'b1;
                ex_flush    = 1'b1;
                mem_flush   = 1'b1;
                pc_redirect = 1'b1;
                state_nx    = if_stall_req ? ST_IWAIT : ST_RUN;
            end
            ST_IWAIT: begin
                // the fetch completing this cycle is stale; discard it too
                if_flush = 1'b1;
                if (!if_stall_req)
                    state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
        if (rst) begin
            if_flush    = 1'b0;
            id_flush    = 1'b0;
            ex_flush    = 1'b0;
            mem_flush   = 1'b0;
            pc_redirect = 1'b0;
        end
    end

    assign ctl_busy      = (cur_st != ST_RUN);
    assign stall_timeout = wdog_flag & ~rst;

    antares_stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .TO_WIDTH      (TO_WIDTH)
    ) u_wdog (
        .clk           (clk),
        .rst           (rst),
        .stall         (id_stall),
        .stall_timeout (wdog_flag)
    );

`ifdef ANTARES_PIPE_PERF_EN
    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (id_stall)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state_q == ST_FLUSH)
                perf_flush_count <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_antares_pipeline_control.sv
// Scoreboard bench for antares_pipeline_control (STALL_TIMEOUT=8).
// Stimulus pushes a hand-computed expected output word per cycle; the
// monitor pops and compares on the falling edge.
module tb_antares_pipeline_control;

    logic clk = 1'b0;
    logic rst;
    logic if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_req;
    logic if_stall, id_stall, ex_stall, mem_stall, wb_stall;
    logic if_flush, id_flush, ex_flush, mem_flush;
    logic pc_redirect, ctl_busy, stall_timeout;
`ifdef ANTARES_PIPE_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    typedef struct {
        string      name;
        logic [11:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // output word: {if,id,ex,mem,wb stall, if,id,ex,mem flush, pc_redirect, ctl_busy, stall_timeout}
    localparam logic [11:0] E_IDLE  = 12'b00000_0000_0_0_0;
    localparam logic [11:0] E_EXST  = 12'b11100_0000_0_0_0;
    localparam logic [11:0] E_MEMST = 12'b11111_0000_0_0_0;
    localparam logic [11:0] E_PEND  = 12'b11111_0000_0_1_0;
    localparam logic [11:0] E_PREL  = 12'b00000_0000_0_1_0;
    localparam logic [11:0] E_FLUSH = 12'b00000_1111_1_1_0;
    localparam logic [11:0] E_FLMS  = 12'b00011_1111_1_1_0;
    localparam logic [11:0] E_IWAIT = 12'b10000_1000_0_1_0;
    localparam logic [11:0] E_IDST  = 12'b11000_0000_0_0_0;
    localparam logic [11:0] E_TO    = 12'b00000_0000_0_0_1;

    always #5 clk = ~clk;

    antares_pipeline_control #(
        .STALL_TIMEOUT (8),
        .TO_WIDTH      (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .id_stall_req  (id_stall_req),
        .ex_stall_req  (ex_stall_req),
        .mem_stall_req (mem_stall_req),
        .exc_req       (exc_req),
        .if_stall      (if_stall),
        .id_stall      (id_stall),
        .ex_stall      (ex_stall),
        .mem_stall     (mem_stall),
        .wb_stall      (wb_stall),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .ex_flush      (ex_flush),
        .mem_flush     (mem_flush),
        .pc_redirect   (pc_redirect),
        .ctl_busy      (ctl_busy),
        .stall_timeout (stall_timeout)
`ifdef ANTARES_PIPE_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    // in = {rst, if_req, id_req, ex_req, mem_req, exc}
    task automatic step(input string name, input logic [5:0] in, input logic [11:0] exp);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_req} = in;
        e.name = name;
        e.exp  = exp;
        q.push_back(e);
    endtask

    // Monitor: one output sample per cycle, compared against the queued expectation.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {if_stall, id_stall, ex_stall, mem_stall, wb_stall,
                       if_flush, id_flush, ex_flush, mem_flush,
                       pc_redirect, ctl_busy, stall_timeout};
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b want %b", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        {rst, if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, exc_req} = 6'b100000;

        // reset and stall chain during reset
        step("rst_idle",   6'b100000, E_IDLE);
        step("rst_exreq",  6'b100100, E_EXST);
        step("idle",       6'b000000, E_IDLE);
        for (int i = 0; i < 3; i++) step("ex_stall", 6'b000100, E_EXST);
        step("ex_release", 6'b000000, E_IDLE);

        // plain exception
        step("exc_run",     6'b000001, E_IDLE);
        step("flush",       6'b000000, E_FLUSH);
        step("after_flush", 6'b000000, E_IDLE);

        // exception behind an outstanding D-memory access
        step("exc_mem",      6'b000011, E_MEMST);
        step("pend1",        6'b000010, E_PEND);
        step("pend2_exc",    6'b000011, E_PEND);
        step("pend3",        6'b000010, E_PEND);
        step("pend_release", 6'b000000, E_PREL);
        step("pend_flush",   6'b000000, E_FLUSH);
        step("pend_done",    6'b000000, E_IDLE);

        // exception with a fetch outstanding past the flush
        step("exc_if",     6'b000001, E_IDLE);
        step("iw_flush",   6'b010000, E_FLUSH);
        step("iwait1",     6'b010000, E_IWAIT);
        step("iwait2_exc", 6'b010001, E_IWAIT);
        step("iwait3",     6'b010000, E_IWAIT);
        step("iwait_fall", 6'b000000, E_IWAIT);
        step("iwait_done", 6'b000000, E_IDLE);

        // MEM/WB holds survive a flush while front stalls are dropped
        step("exc_b",       6'b000001, E_IDLE);
        step("flush_memst", 6'b000110, E_FLMS);
        step("post_flmst",  6'b000000, E_IDLE);

        // watchdog: 7 stalled cycles is one short
        for (int i = 0; i < 7; i++) step("stall7", 6'b001000, E_IDST);
        step("stall7_clr", 6'b000000, E_IDLE);
        // 8 stalled cycles trips it; flag visible after the 8th edge
        for (int i = 0; i < 8; i++) step("stall8", 6'b001000, E_IDST);
        step("timeout_set",    6'b000000, E_TO);
        step("timeout_sticky", 6'b000000, E_TO);
        step("rst_clears_to",  6'b100000, E_IDLE);
        step("after_rst",      6'b000000, E_IDLE);

        // reset mid-sequence
        step("exc_c",        6'b000001, E_IDLE);
        step("rst_in_flush", 6'b100000, E_IDLE);
        step("no_redirect",  6'b000000, E_IDLE);
        step("exc_d",        6'b000011, E_MEMST);
        step("rst_in_pend",  6'b100010, E_MEMST);
        step("pend_gone",    6'b000000, E_IDLE);
        step("still_run",    6'b000000, E_IDLE);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
